trace_buffer: RTL and testbench

- Synthesizable retire-trace capture block for the RV32I core; replaces testbench-only cycle/pc/register printing with an on-chip record.
- Snoops the core's retire/writeback signals and stamps each retire with a free-running cycle count.
- Stores entries in a parametrised ring buffer, read out over a valid/ready port.
- Adds a PC trigger, wrap/stop capture modes, overflow and drop accounting, and a software clear.

---
 rtl/trace_pkg.sv | 22 ++
 rtl/trace_ring_fifo.sv | 70 +++++++
 rtl/trace_buffer.sv | 145 ++++++++++++++
 tb/tb_trace_buffer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types, constants and entry layout for the retire trace buffer
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        FROZEN  = 2'd3
    } trace_state_t;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_STOP = 1'b1;

    localparam int INSN_W    = 32;
    localparam int RD_ADDR_W = 5;

    // Packed entry layout: {cycle, pc, insn, rd_we, rd_addr, rd_data}
    function automatic int entry_width(input int xlen, input int cyc_w);
        return cyc_w + xlen + INSN_W + 1 + RD_ADDR_W + xlen;
    endfunction

endpackage

// File: rtl/trace_ring_fifo.sv
// rtl/trace_ring_fifo.sv - generic DEPTH x W ring FIFO with overwrite-oldest and FWFT head
module trace_ring_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     overwrite_en,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overwrite
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = pop && !w_empty && !clear;
    // A push into a full ring is accepted only when a pop frees the slot or overwrite is allowed.
    assign w_do_push = push && !clear && (!w_full || w_do_pop || overwrite_en);
    assign overwrite = w_do_push && w_full && !w_do_pop;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop || overwrite) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop && !overwrite) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/trace_buffer.sv
// rtl/trace_buffer.sv - retire-trace capture with trigger, wrap/stop modes and drop accounting
module trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 16,
    parameter int CYC_W  = 16,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     clear,
    input  logic                     mode,
    input  logic                     trig_en,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic                     retire_valid,
    input  logic [XLEN-1:0]          retire_pc,
    input  logic [INSN_W-1:0]        retire_insn,
    input  logic                     rd_we,
    input  logic [RD_ADDR_W-1:0]     rd_addr,
    input  logic [XLEN-1:0]          rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CYC_W-1:0]         out_cycle,
    output logic [XLEN-1:0]          out_pc,
    output logic [INSN_W-1:0]        out_insn,
    output logic                     out_rd_we,
    output logic [RD_ADDR_W-1:0]     out_rd_addr,
    output logic [XLEN-1:0]          out_rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        dropped,
    output logic [1:0]               state
);
    localparam int EW = entry_width(XLEN, CYC_W);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CYC_W-1:0]  r_cycle;
    trace_state_t      r_state;
    logic              r_overflow;
    logic [DROP_W-1:0] r_dropped;

    logic          w_hit;
    logic          w_want;
    logic          w_block;
    logic          w_push;
    logic          w_pop;
    logic          w_fills;
    logic          w_to_frozen;
    logic          w_overwrite;
    logic [EW-1:0] w_wdata;
    logic [EW-1:0] w_head;

    assign w_hit = retire_valid && (retire_pc == trig_pc);

    always_comb begin
        w_want = 1'b0;
        unique case (r_state)
            ARMED:   w_want = en && w_hit;
            CAPTURE: w_want = retire_valid;
            default: w_want = 1'b0;
        endcase
    end

    // In STOP mode a full buffer never accepts another entry, even with a pop in the same cycle.
    assign w_block     = (mode == MODE_STOP) && (count == CW'(DEPTH));
    assign w_push      = w_want && !w_block && !clear;
    assign w_pop       = out_valid && out_ready;
    assign w_fills     = w_push && !w_pop && (count == CW'(DEPTH - 1));
    assign w_to_frozen = w_want && (w_block || ((mode == MODE_STOP) && w_fills));
    assign w_wdata     = {r_cycle, retire_pc, retire_insn, rd_we, rd_addr, rd_data};

    trace_ring_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ring (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .push         (w_push),
        .pop          (w_pop),
        .overwrite_en (mode == MODE_WRAP),
        .wdata        (w_wdata),
        .head         (w_head),
        .count        (count),
        .overwrite    (w_overwrite)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle    <= '0;
            r_state    <= IDLE;
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            if (clear) begin
                r_state    <= IDLE;
                r_overflow <= 1'b0;
                r_dropped  <= '0;
            end else begin
                if (w_overwrite) begin
                    r_overflow <= 1'b1;
                end
                if (((r_state == FROZEN) && retire_valid) || (w_want && w_block)) begin
                    if (r_dropped != '1) begin
                        r_dropped <= r_dropped + 1'b1;
                    end
                end
                unique case (r_state)
                    IDLE: begin
                        if (en) begin
                            r_state <= trig_en ? ARMED : CAPTURE;
                        end
                    end
                    ARMED: begin
                        if (!en) begin
                            r_state <= IDLE;
                        end else if (w_to_frozen) begin
                            r_state <= FROZEN;
                        end else if (w_hit) begin
                            r_state <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (!en) begin
                            r_state <= IDLE;
                        end else if (w_to_frozen) begin
                            r_state <= FROZEN;
                        end
                    end
                    default: r_state <= FROZEN;
                endcase
            end
        end
    end

    assign out_valid = (count != '0);
    assign {out_cycle, out_pc, out_insn, out_rd_we, out_rd_addr, out_rd_data} = w_head;
    assign overflow  = r_overflow;
    assign dropped   = r_dropped;
    assign state     = r_state;

endmodule

// File: tb/tb_trace_buffer.sv
// tb/tb_trace_buffer.sv - randomized self-checking bench for trace_buffer against a queue model
module tb_trace_buffer;
    localparam int XLEN   = 32;
    localparam int DEPTH  = 16;
    localparam int CYC_W  = 16;
    localparam int DROP_W = 8;

    logic              clk;
    logic              reset;
    logic              en;
    logic              clear;
    logic              mode;
    logic              trig_en;
    logic [XLEN-1:0]   trig_pc;
    logic              retire_valid;
    logic [XLEN-1:0]   retire_pc;
    logic [31:0]       retire_insn;
    logic              rd_we;
    logic [4:0]        rd_addr;
    logic [XLEN-1:0]   rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [CYC_W-1:0]  out_cycle;
    logic [XLEN-1:0]   out_pc;
    logic [31:0]       out_insn;
    logic              out_rd_we;
    logic [4:0]        out_rd_addr;
    logic [XLEN-1:0]   out_rd_data;
    logic [4:0]        count;
    logic              overflow;
    logic [DROP_W-1:0] dropped;
    logic [1:0]        state;

    trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CYC_W(CYC_W), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .mode(mode),
        .trig_en(trig_en), .trig_pc(trig_pc), .retire_valid(retire_valid),
        .retire_pc(retire_pc), .retire_insn(retire_insn), .rd_we(rd_we),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_cycle(out_cycle), .out_pc(out_pc),
        .out_insn(out_insn), .out_rd_we(out_rd_we), .out_rd_addr(out_rd_addr),
        .out_rd_data(out_rd_data), .count(count), .overflow(overflow),
        .dropped(dropped), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cyc;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        we;
        logic [4:0]  ra;
        logic [31:0] rd;
    } ent_t;

    ent_t q[$];
    int   m_state;
    int   m_cycle;
    int   m_drop;
    bit   m_ovf;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_state = 0;
        m_cycle = 0;
        m_drop  = 0;
        m_ovf   = 0;
    endtask

    task automatic model_step();
        bit   pop;
        bit   want;
        bit   blocked;
        ent_t e;
        pop  = (q.size() != 0) && out_ready;
        want = 0;
        e.cyc = 16'(m_cycle); e.pc = retire_pc; e.insn = retire_insn;
        e.we = rd_we; e.ra = rd_addr; e.rd = rd_data;
        if (clear) begin
            model_reset_keep_cycle();
        end else begin
            case (m_state)
                0: if (en) m_state = trig_en ? 1 : 2;
                1: if (!en) m_state = 0;
                   else if (retire_valid && retire_pc == trig_pc) begin want = 1; m_state = 2; end
                2: begin want = retire_valid; if (!en) m_state = 0; end
                default: if (retire_valid && m_drop < 255) m_drop++;
            endcase
            blocked = want && mode && (q.size() == DEPTH);
            if (blocked) begin
                if (m_drop < 255) m_drop++;
                if (m_state == 2) m_state = 3;
            end
            if (pop) void'(q.pop_front());
            if (want && !blocked) begin
                if (q.size() == DEPTH) begin
                    void'(q.pop_front());
                    m_ovf = 1;
                end
                q.push_back(e);
                if (mode && q.size() == DEPTH && m_state == 2) m_state = 3;
            end
        end
        m_cycle = (m_cycle + 1) % 65536;
    endtask

    task automatic model_reset_keep_cycle();
        q.delete();
        m_state = 0;
        m_drop  = 0;
        m_ovf   = 0;
    endtask

    task automatic check_all();
        check("count", 64'(count), 64'(q.size()));
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("state", 64'(state), 64'(m_state));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("dropped", 64'(dropped), 64'(m_drop));
        if (q.size() != 0) begin
            check("head_cycle", 64'(out_cycle), 64'(q[0].cyc));
            check("head_pc", 64'(out_pc), 64'(q[0].pc));
            check("head_insn", 64'(out_insn), 64'(q[0].insn));
            check("head_rd_we", 64'(out_rd_we), 64'(q[0].we));
            check("head_rd_addr", 64'(out_rd_addr), 64'(q[0].ra));
            check("head_rd_data", 64'(out_rd_data), 64'(q[0].rd));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        retire_valid = 1'b0;
        cycle();
    endtask

    task automatic retire(input logic [31:0] pc);
        retire_valid = 1'b1;
        retire_pc    = pc;
        retire_insn  = $urandom;
        rd_we        = 1'($urandom_range(0, 1));
        rd_addr      = 5'($urandom_range(0, 31));
        rd_data      = $urandom;
        cycle();
        retire_valid = 1'b0;
    endtask

    task automatic do_clear();
        retire_valid = 1'b0;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; clear = 1'b0; mode = 1'b0; trig_en = 1'b0;
        trig_pc = '0; retire_valid = 1'b0; retire_pc = '0; retire_insn = '0;
        rd_we = 1'b0; rd_addr = '0; rd_data = '0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        reset = 1'b1;

        // Basic capture
        en = 1'b1;
        idle();
        retire(32'h0); retire(32'h4); retire(32'h8);
        check("t1_count", 64'(count), 64'd3);
        check("t1_head_pc", 64'(out_pc), 64'h0);
        do_clear();

        // Trigger
        trig_en = 1'b1; trig_pc = 32'h10;
        idle();
        for (int pc = 0; pc <= 32'h18; pc += 4) begin
            retire(32'(pc));
            check("t2_state", 64'(state), (pc < 32'h10) ? 64'd1 : 64'd2);
        end
        check("t2_count", 64'(count), 64'd3);
        check("t2_head_pc", 64'(out_pc), 64'h10);
        trig_en = 1'b0;
        do_clear();

        // WRAP overflow
        idle();
        for (int i = 0; i < 20; i++) retire(32'h100 + 32'(4 * i));
        check("t3_count", 64'(count), 64'd16);
        check("t3_overflow", 64'(overflow), 64'd1);
        check("t3_head_pc", 64'(out_pc), 64'h110);
        do_clear();

        // STOP freeze, drain, clear
        mode = 1'b1;
        idle();
        for (int i = 0; i < 20; i++) begin
            retire(32'h200 + 32'(4 * i));
            if (i == 14) check("t4_not_frozen", 64'(state), 64'd2);
            if (i == 15) check("t4_frozen", 64'(state), 64'd3);
        end
        check("t4_dropped", 64'(dropped), 64'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t4_drain_pc", 64'(out_pc), 64'h200 + 64'(4 * i));
            idle();
        end
        check("t4_empty", 64'(out_valid), 64'd0);
        check("t4_still_frozen", 64'(state), 64'd3);
        out_ready = 1'b0;
        do_clear();
        check("t4_clear_state", 64'(state), 64'd0);
        check("t4_clear_dropped", 64'(dropped), 64'd0);

        // Full with simultaneous push and pop
        mode = 1'b0;
        idle();
        for (int i = 0; i < 16; i++) retire(32'h300 + 32'(4 * i));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) retire(32'h400 + 32'(4 * i));
        check("t5_count", 64'(count), 64'd16);
        check("t5_overflow", 64'(overflow), 64'd0);
        check("t5_head_pc", 64'(out_pc), 64'h30c);
        out_ready = 1'b0;
        do_clear();

        // Dropped counter saturation
        mode = 1'b1;
        idle();
        for (int i = 0; i < 280; i++) retire(32'h500 + 32'(4 * (i % 16)));
        check("t7_drop_sat", 64'(dropped), 64'd255);
        mode = 1'b0;
        do_clear();

        // Asynchronous reset mid-capture
        idle();
        for (int i = 0; i < 7; i++) retire(32'h600 + 32'(4 * i));
        check("t6_count", 64'(count), 64'd7);
        reset = 1'b0;
        #1;
        check("t6_async_count", 64'(count), 64'd0);
        check("t6_async_valid", 64'(out_valid), 64'd0);
        check("t6_async_state", 64'(state), 64'd0);
        check("t6_async_pc", 64'(out_pc), 64'd0);
        check("t6_async_cycle", 64'(out_cycle), 64'd0);
        check("t6_async_ovf", 64'(overflow), 64'd0);
        check("t6_async_drop", 64'(dropped), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        idle();
        retire(32'h700);
        check("t6_restart_cycle", 64'(out_cycle), 64'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            en           = ($urandom_range(0, 15) != 0);
            trig_en      = 1'($urandom_range(0, 1));
            trig_pc      = 32'(4 * $urandom_range(0, 7));
            retire_valid = 1'($urandom_range(0, 1));
            retire_pc    = 32'(4 * $urandom_range(0, 7));
            retire_insn  = $urandom;
            rd_we        = 1'($urandom_range(0, 1));
            rd_addr      = 5'($urandom_range(0, 31));
            rd_data      = $urandom;
            out_ready    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) mode = ~mode;
            clear        = ($urandom_range(0, 199) == 0);
            cycle();
        end
        clear = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
